// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: RX/TX byte FIFOs, TX launch scheduler, CON register, irq.
// Bus reads are combinational; pops and register updates take effect at the clock edge.

// Generic synchronous FIFO; head word is visible combinationally while non-empty.
// Latency: a push is visible at head one cycle later.
// Backpressure: a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_bus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdat,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// CPU-facing UART controller around the existing receiver/transmitter pair.
// Latency: RX byte readable one cycle after rx_valid; tx_start two cycles after a TXD write when idle.
// Backpressure: none on the bus; full-FIFO writes/receives are dropped and flagged in CON.
module uart_bus_ctrl #(
    parameter int          RX_DEPTH = 4,
    parameter int          TX_DEPTH = 4,
    parameter logic [7:0]  ADDR_TXD = 8'h18,
    parameter logic [7:0]  ADDR_RXD = 8'h1C,
    parameter logic [7:0]  ADDR_CON = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        irq
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic       launch;
    logic       tx_done_set;

    logic       rd_con;
    logic       rd_rxd;
    logic       wr_con;
    logic       wr_txd;

    logic [7:0] rx_head;
    logic       rx_empty;
    logic       rx_full;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_full;

    logic       tx_int_en;
    logic       rx_int_en;
    logic       tx_done;
    logic       rx_overrun;
    logic       tx_drop;
    logic       rx_overrun_set;
    logic       tx_drop_set;
    logic       unused_wdata;

    assign rd_con = rd & (addr == ADDR_CON);
    assign rd_rxd = rd & (addr == ADDR_RXD);
    assign wr_con = wr & (addr == ADDR_CON);
    assign wr_txd = wr & (addr == ADDR_TXD);

    assign unused_wdata = ^wdata[31:8];

    uart_bus_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rx_valid),
        .pop      (rd_rxd),
        .wdat     (rx_data),
        .head_dat (rx_head),
        .empty    (rx_empty),
        .full     (rx_full)
    );

    uart_bus_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_txd),
        .pop      (launch),
        .wdat     (wdata[7:0]),
        .head_dat (tx_head),
        .empty    (tx_empty),
        .full     (tx_full)
    );

    // A full FIFO still accepts a byte when the same cycle pops one.
    assign rx_overrun_set = rx_valid & rx_full & ~rd_rxd;
    assign tx_drop_set    = wr_txd & tx_full & ~launch;

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        tx_done_set = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                launch    = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    tx_done_set = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            tx_start <= launch;
            if (launch) begin
                tx_data <= tx_head;
            end
        end
    end

    // Sticky bits: a set in the same cycle as a CON read wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_int_en  <= 1'b0;
            rx_int_en  <= 1'b0;
            tx_done    <= 1'b0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (wr_con) begin
                tx_int_en <= wdata[0];
                rx_int_en <= wdata[1];
            end
            tx_done    <= tx_done_set    | (tx_done    & ~rd_con);
            rx_overrun <= rx_overrun_set | (rx_overrun & ~rd_con);
            tx_drop    <= tx_drop_set    | (tx_drop    & ~rd_con);
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            if (addr == ADDR_TXD) begin
                rdata = {24'h0, tx_data};
            end else if (addr == ADDR_RXD) begin
                rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            end else if (addr == ADDR_CON) begin
                rdata = {25'h0, tx_drop, rx_overrun, tx_full, ~rx_empty,
                         tx_done, rx_int_en, tx_int_en};
            end
        end
    end

    assign irq = (tx_int_en & tx_done) | (rx_int_en & ~rx_empty);
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Bench for uart_bus_ctrl: vector table for bus/RX behaviour, scoreboard for TX launches.
module tb_uart_bus_ctrl;
    localparam logic [7:0] A_TXD = 8'h18;
    localparam logic [7:0] A_RXD = 8'h1C;
    localparam logic [7:0] A_CON = 8'h20;

    localparam int OP_IDLE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;
    localparam int OP_RX   = 3;
    localparam int OP_RXRD = 4;
    localparam int OP_PEEK = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  addr = 8'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_bus_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .irq      (irq)
    );

    always #10 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
    int   busy_cnt = 0;
    int   busy_len = 5208;
    logic model_en = 1'b1;
    logic hold_busy = 1'b0;

    always @(posedge clk) begin
        if (model_en && tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) | hold_busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard of bytes expected on the transmitter, in launch order.
    logic [7:0] sb_q[$];
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                check("tx_start width", {31'b0, prev_start}, 32'h0);
                check("tx_start while busy", {31'b0, tx_busy}, 32'h0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got launch of 0x%0h expected none", tx_data);
                end else begin
                    check("tx_data", {24'b0, tx_data}, {24'b0, sb_q.pop_front()});
                end
            end
            prev_start = tx_start;
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp,
                          input logic exp_irq, input string nm);
        rd = 1'b1; addr = a;
        #1;
        check({nm, " rdata"}, rdata, exp);
        check({nm, " irq"}, {31'b0, irq}, {31'b0, exp_irq});
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b, input logic expect_sent);
        if (expect_sent) sb_q.push_back(b);
        bus_write(A_TXD, {24'h0, b});
    endtask

    typedef struct {
        int          op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int op, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] e, input logic i);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.exp_rdata = e; v.exp_irq = i;
        vecs.push_back(v);
    endtask

    initial begin
        int n;

        // Vectors applied right after the mid-frame reset.
        add_vec(OP_PEEK, A_CON, 0, 32'h00, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h00, 1'b0);
        add_vec(OP_WR,   A_CON, 32'h3, 0, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h03, 1'b0);
        add_vec(OP_RX,   0, 32'h71, 0, 1'b0);
        add_vec(OP_IDLE, 0, 100, 0, 1'b0);
        add_vec(OP_RX,   0, 32'h49, 0, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h0B, 1'b1);
        add_vec(OP_RD,   A_RXD, 0, 32'h71, 1'b1);
        add_vec(OP_RD,   A_RXD, 0, 32'h49, 1'b1);
        add_vec(OP_RD,   A_RXD, 0, 32'h00, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h03, 1'b0);
        add_vec(OP_WR,   A_CON, 32'h0, 0, 1'b0);
        for (int b = 1; b <= 4; b++) add_vec(OP_RX, 0, b, 0, 1'b0);
        add_vec(OP_RXRD, A_RXD, 32'h05, 32'h01, 1'b0);
        add_vec(OP_RX,   0, 32'h06, 0, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h28, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h08, 1'b0);
        for (int b = 2; b <= 5; b++) add_vec(OP_RD, A_RXD, 0, b, 1'b0);
        add_vec(OP_RD,   A_RXD, 0, 32'h00, 1'b0);
        add_vec(OP_RD,   A_CON, 0, 32'h00, 1'b0);
        add_vec(OP_RD,   A_TXD, 0, 32'h00, 1'b0);
        add_vec(OP_RD,   8'h00, 0, 32'h00, 1'b0);

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Activity before an asynchronous mid-frame reset.
        bus_write(A_CON, 32'h3);
        rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        #1 check("irq before reset", {31'b0, irq}, 32'h1);
        tx_write(8'h5A, 1'b1);
        n = 0;
        while (tx_data !== 8'h5A && n < 20) begin @(negedge clk); n++; end
        check("first launch seen", {24'b0, tx_data}, 32'h5A);
        #3 reset = 1'b1;
        rd = 1'b1; addr = A_CON;
        #1;
        check("reset rdata", rdata, 32'h0);
        check("reset tx_start", {31'b0, tx_start}, 32'h0);
        check("reset tx_data", {24'b0, tx_data}, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RD: rd_chk(vecs[i].a, vecs[i].exp_rdata, vecs[i].exp_irq,
                              $sformatf("vec%0d", i));
                OP_WR: bus_write(vecs[i].a, vecs[i].d);
                OP_RX: begin
                    rx_valid = 1'b1; rx_data = vecs[i].d[7:0];
                    @(negedge clk);
                    rx_valid = 1'b0;
                end
                OP_RXRD: begin
                    rx_valid = 1'b1; rx_data = vecs[i].d[7:0];
                    rd_chk(vecs[i].a, vecs[i].exp_rdata, vecs[i].exp_irq,
                           $sformatf("vec%0d", i));
                    rx_valid = 1'b0;
                end
                OP_PEEK: begin
                    rd = 1'b0; addr = vecs[i].a;
                    #1 check($sformatf("vec%0d peek", i), rdata, vecs[i].exp_rdata);
                    @(negedge clk);
                end
                default: repeat (vecs[i].d) @(negedge clk);
            endcase
        end

        // TX sequencing at the real frame length.
        n = 0;
        while (tx_busy && n < 6000) begin @(negedge clk); n++; end
        check("tx idle before seq", {31'b0, tx_busy}, 32'h0);
        tx_write(8'h55, 1'b1);
        tx_write(8'hAA, 1'b1);
        tx_write(8'h0F, 1'b1);
        n = 0;
        while ((sb_q.size() != 0 || tx_busy) && n < 20000) begin @(negedge clk); n++; end
        check("tx seq drained", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        rd_chk(A_TXD, 32'h0F, 1'b0, "txd last");
        rd_chk(A_CON, 32'h04, 1'b0, "tx_done set");
        rd_chk(A_CON, 32'h00, 1'b0, "tx_done clear");

        // TX full and drop while the transmitter is held busy.
        busy_len = 20;
        hold_busy = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 5; b++) tx_write(8'h11 + 8'(b), b < 4);
        rd_chk(A_CON, 32'h50, 1'b0, "tx full drop");
        rd_chk(A_CON, 32'h10, 1'b0, "tx drop clear");
        hold_busy = 1'b0;
        n = 0;
        while ((sb_q.size() != 0 || tx_busy) && n < 500) begin @(negedge clk); n++; end
        check("drop seq drained", sb_q.size(), 0);
        repeat (10) @(negedge clk);
        rd_chk(A_TXD, 32'h14, 1'b0, "txd after drop");
        rd_chk(A_CON, 32'h04, 1'b0, "done after drop");

        // tx_done set coincides with a CON read: the set wins.
        model_en = 1'b0;
        bus_write(A_CON, 32'h1);
        tx_write(8'h3C, 1'b1);
        n = 0;
        while (tx_data !== 8'h3C && n < 20) begin @(negedge clk); n++; end
        check("irq test launch", {24'b0, tx_data}, 32'h3C);
        @(negedge clk);
        hold_busy = 1'b1;
        @(negedge clk);
        hold_busy = 1'b0;
        rd_chk(A_CON, 32'h01, 1'b0, "con read at done");
        rd_chk(A_CON, 32'h05, 1'b1, "done survives clear");
        rd_chk(A_CON, 32'h01, 1'b0, "done cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
